// File: rtl/ascon_sbox_layer_serial_pkg.sv
// Shared types and helpers for the serial Ascon constant-addition + substitution layer.
package ascon_sbox_layer_serial_pkg;

    localparam int unsigned ASCON_COLUMNS = 64;

    typedef logic [4:0]  bv5_t;
    typedef logic [7:0]  bv8_t;
    typedef logic [63:0] bv64_t;

    // x0 occupies the most significant word, x4 the least.
    typedef struct packed {
        bv64_t x0;
        bv64_t x1;
        bv64_t x2;
        bv64_t x3;
        bv64_t x4;
    } ascon_state_t;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} sbox_fsm_e;

    // p_C: the round constant only touches the low byte of x2.
    function automatic ascon_state_t add_round_constant(ascon_state_t s, bv8_t rc);
        ascon_state_t r;
        r = s;
        r.x2[7:0] = s.x2[7:0] ^ rc;
        return r;
    endfunction

endpackage

// File: rtl/ascon_sbox.sv
// Single-column Ascon 5-bit sbox in its bitsliced form; column[4] is x0.
module ascon_sbox
    import ascon_sbox_layer_serial_pkg::*;
(
    input  bv5_t column,
    output bv5_t result
);

    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    logic b0, b1, b2, b3, b4;

    // Input mixing
    assign a0 = column[4] ^ column[0];
    assign a1 = column[3];
    assign a2 = column[2] ^ column[3];
    assign a3 = column[1];
    assign a4 = column[0] ^ column[1];

    // Chi-like nonlinear step
    assign t0 = ~a0 & a1;
    assign t1 = ~a1 & a2;
    assign t2 = ~a2 & a3;
    assign t3 = ~a3 & a4;
    assign t4 = ~a4 & a0;

    assign b0 = a0 ^ t1;
    assign b1 = a1 ^ t2;
    assign b2 = a2 ^ t3;
    assign b3 = a3 ^ t4;
    assign b4 = a4 ^ t0;

    // Output mixing and final inversion of x2
    assign result = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};

endmodule

// File: rtl/ascon_sbox_layer_serial.sv
// Iterative p_C + p_S over the 320-bit Ascon state, LANES sbox columns per cycle.
module ascon_sbox_layer_serial
    import ascon_sbox_layer_serial_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [319:0] in_state_i,
    input  logic [7:0]   in_rc_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] out_state_o
);

    localparam int unsigned Beats = ASCON_COLUMNS / LANES;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned ColsW = LANES * 5;

    if ((LANES == 0) || (LANES > 64) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_check
        $fatal(1, "ascon_sbox_layer_serial: LANES must be one of 1,2,4,8,16,32,64");
    end

    // Pure column gather: lane l holds column base+l, x0 as the MSB.
    function automatic logic [ColsW-1:0] gather_columns(ascon_state_t s, logic [5:0] base);
        logic [ColsW-1:0] cols;
        logic [5:0]       j;
        cols = '0;
        for (int l = 0; l < LANES; l++) begin
            j = base + 6'(l);
            cols[5*l +: 5] = {s.x0[j], s.x1[j], s.x2[j], s.x3[j], s.x4[j]};
        end
        return cols;
    endfunction

    // Pure column scatter: inverse mapping of gather_columns.
    function automatic ascon_state_t scatter_columns(ascon_state_t s, logic [ColsW-1:0] cols,
                                                     logic [5:0] base);
        ascon_state_t r;
        logic [5:0]   j;
        r = s;
        for (int l = 0; l < LANES; l++) begin
            j = base + 6'(l);
            {r.x0[j], r.x1[j], r.x2[j], r.x3[j], r.x4[j]} = cols[5*l +: 5];
        end
        return r;
    endfunction

    sbox_fsm_e        fsm;
    ascon_state_t     state;
    logic [BeatW-1:0] beat;
    logic             out_valid;

    logic [5:0]       col_base;
    logic [ColsW-1:0] sbox_in;
    logic [ColsW-1:0] sbox_out;
    ascon_state_t     state_sub;

    assign col_base  = 6'(32'(beat) * LANES);
    assign sbox_in   = gather_columns(state, col_base);
    assign state_sub = scatter_columns(state, sbox_out, col_base);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ascon_sbox u_sbox (
            .column (sbox_in[5*l +: 5]),
            .result (sbox_out[5*l +: 5])
        );
    end

    // Control FSM, state register, beat counter and registered output valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm       <= StIdle;
            state     <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (fsm)
                StIdle: begin
                    if (in_valid_i) begin
                        state <= add_round_constant(ascon_state_t'(in_state_i), bv8_t'(in_rc_i));
                        beat  <= '0;
                        fsm   <= StBusy;
                    end
                end
                StBusy: begin
                    state <= state_sub;
                    if (beat == BeatW'(Beats - 1)) begin
                        beat      <= '0;
                        fsm       <= StDone;
                        out_valid <= 1'b1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                StDone: begin
                    // Acceptance resumes only from the following cycle.
                    if (out_ready_i) begin
                        fsm       <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = (fsm == StIdle);
    assign out_valid_o = out_valid;
    assign out_state_o = state;

endmodule

// File: tb/tb_ascon_sbox_layer_serial.sv
// Self-checking bench: three DUTs (LANES=4,1,64) checked against a table-driven p_C+p_S model.
module tb_ascon_sbox_layer_serial;

    localparam logic [4:0] SBOX_TBL [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [319:0] in_state;
    logic [7:0]   in_rc;
    logic         out_ready;
    logic [319:0] out_state [3];

    logic [319:0] exp_q [$];
    int checks;
    int errors;

    always #5 clk = ~clk;

    ascon_sbox_layer_serial #(.LANES(4)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .in_state_i  (in_state),
        .in_rc_i     (in_rc),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready),
        .out_state_o (out_state[0])
    );

    ascon_sbox_layer_serial #(.LANES(1)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .in_state_i  (in_state),
        .in_rc_i     (in_rc),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready),
        .out_state_o (out_state[1])
    );

    ascon_sbox_layer_serial #(.LANES(64)) u_dut64 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid[2]),
        .in_ready_o  (in_ready[2]),
        .in_state_i  (in_state),
        .in_rc_i     (in_rc),
        .out_valid_o (out_valid[2]),
        .out_ready_i (out_ready),
        .out_state_o (out_state[2])
    );

    function automatic logic [319:0] model(logic [319:0] s, logic [7:0] rc);
        logic [63:0]  x [5];
        logic [4:0]   c;
        logic [4:0]   r;
        logic [319:0] t;
        t = s;
        t[135:128] = t[135:128] ^ rc;
        for (int i = 0; i < 5; i++) x[i] = t[319 - 64*i -: 64];
        for (int j = 0; j < 64; j++) begin
            c = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            r = SBOX_TBL[c];
            {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]} = r;
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one state on DUT k, check latency/handshake, optionally stall in DONE.
    task automatic run_txn(input int k, input logic [319:0] s, input logic [7:0] rc,
                           input logic [319:0] expv, input int lat, input int hold,
                           input string name);
        int           edges;
        bit           ready_low;
        bit           stable;
        logic [319:0] got;
        logic [319:0] want;
        exp_q.push_back(expv);
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b expected 1", name, in_ready[k]);
        end
        in_state    = s;
        in_rc       = rc;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        in_state    = ~s;
        edges       = 0;
        ready_low   = 1'b1;
        while (out_valid[k] !== 1'b1 && edges < 200) begin
            if (in_ready[k] !== 1'b0) ready_low = 1'b0;
            tick();
            edges++;
        end
        checks++;
        if (edges != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges expected %0d", name, edges, lat);
        end
        checks++;
        if (!ready_low) begin
            errors++;
            $display("FAIL %s busy_ready: got in_ready high while busy expected low", name);
        end
        got  = out_state[k];
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, got, want);
        end
        // Stall in DONE while poking in_valid; nothing may move.
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = i[0];
            tick();
            if (out_valid[k] !== 1'b1 || out_state[k] !== want || in_ready[k] !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) begin
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL %s backpressure_stable: got out_valid=%b in_ready=%b expected 1/0",
                         name, out_valid[k], in_ready[k]);
            end
        end
        checks++;
        if (in_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_ready: got %b expected 0", name, in_ready[k]);
        end
        // Release with in_valid high: the DONE->IDLE edge must not load it.
        in_valid[k] = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        out_ready   = 1'b0;
        checks++;
        if ({out_valid[k], in_ready[k]} !== 2'b01) begin
            errors++;
            $display("FAIL %s release: got valid/ready %b%b expected 01",
                     name, out_valid[k], in_ready[k]);
        end
        checks++;
        if (out_state[k] !== want) begin
            errors++;
            $display("FAIL %s no_load_on_release: got %h expected %h", name, out_state[k], want);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_state  = '0;
        in_rc     = '0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({in_ready[k], out_valid[k]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got ready/valid %b%b expected 10",
                         k, in_ready[k], out_valid[k]);
            end
            checks++;
            if (out_state[k] !== 320'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h expected 0", k, out_state[k]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_txn(0, 320'd0, 8'h00, {64'h0, 64'h0, ONES, 64'h0, 64'h0}, 16, 0, "zero_rc00");
        run_txn(0, 320'd0, 8'hF0,
                {64'hF0, 64'hF0, 64'hFFFF_FFFF_FFFF_FF0F, 64'hF0, 64'h0}, 16, 0, "zero_rcF0");
        run_txn(0, {5{ONES}}, 8'h00, {ONES, 64'h0, ONES, ONES, ONES}, 16, 0, "ones_rc00");
    endtask

    task automatic test_random_lanes();
        logic [319:0] s;
        logic [7:0]   rc;
        for (int i = 0; i < 3; i++) begin
            s  = rand_state();
            rc = 8'($urandom);
            run_txn(1, s, rc, model(s, rc), 64, 0, "rand_lanes1");
        end
        for (int i = 0; i < 4; i++) begin
            s  = rand_state();
            rc = 8'($urandom);
            run_txn(2, s, rc, model(s, rc), 1, 0, "rand_lanes64");
        end
        for (int i = 0; i < 3; i++) begin
            s  = rand_state();
            rc = 8'($urandom);
            run_txn(0, s, rc, model(s, rc), 16, 0, "rand_lanes4");
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] s;
        s = rand_state();
        run_txn(0, s, 8'h5A, model(s, 8'h5A), 16, 10, "backpressure");
    endtask

    task automatic test_mid_reset();
        logic [319:0] s;
        s           = rand_state();
        in_state    = s;
        in_rc       = 8'h3C;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({in_ready[0], out_valid[0]} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_flags: got ready/valid %b%b expected 10",
                     in_ready[0], out_valid[0]);
        end
        checks++;
        if (out_state[0] !== 320'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got %h expected 0", out_state[0]);
        end
        rst_n = 1'b1;
        tick();
        s = rand_state();
        run_txn(0, s, 8'h96, model(s, 8'h96), 16, 0, "after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random_lanes();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
